pp_bank_sched: RTL



---
 rtl/pp_pkg.sv | 17 +
 rtl/pp_wr_chan.sv | 88 ++++++++
 rtl/pp_bank_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pp_pkg.sv
// Shared types and flattened-port index helpers for the ping-pong bank scheduler.
package pp_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_RELEASE} rd_state_t;

  function automatic int unsigned bank_idx(int unsigned ch, int unsigned bank);
    return ch * 2 + bank;
  endfunction

  function automatic int unsigned addr_lsb(int unsigned ch, int unsigned bank,
                                           int unsigned aw);
    return bank_idx(ch, bank) * aw;
  endfunction

endpackage

// File: rtl/pp_wr_chan.sv
// One channel's writer: owns the channel's two bank states, write bank select,
// write address and slice counter; the shared reader marks banks READING/EMPTY.
module pp_wr_chan
  import pp_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int TOTAL_MODULES = 4,
  parameter int SLICE_WIDTH   = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [SLICE_WIDTH-1:0]  slicing_idx_o,
  output logic [1:0]              wea_o,
  output logic [2*ADDR_WIDTH-1:0] addra_o,
  input  logic                    rd_bank_i,
  input  logic                    rd_start_i,
  input  logic                    rd_release_i,
  output logic [1:0]              bank_full_o
);

  bank_state_t            state_q [2];
  bank_state_t            state_d [2];
  logic                   wr_sel_q, wr_sel_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [SLICE_WIDTH-1:0] slice_q, slice_d;
  logic                   accept;
  logic                   last_beat;

  assign in_ready_o    = (state_q[wr_sel_q] == EMPTY) || (state_q[wr_sel_q] == FILLING);
  assign accept        = in_valid_i && in_ready_o;
  assign last_beat     = (wr_addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign slicing_idx_o = slice_q;
  assign bank_full_o   = {state_q[1] == FULL, state_q[0] == FULL};

  always_comb begin
    wea_o           = '0;
    addra_o         = '0;
    wea_o[wr_sel_q] = accept;
    if (wr_sel_q) addra_o[2*ADDR_WIDTH-1:ADDR_WIDTH] = wr_addr_q;
    else          addra_o[ADDR_WIDTH-1:0]            = wr_addr_q;
  end

  always_comb begin
    state_d   = state_q;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    slice_d   = slice_q;
    if (accept) begin
      slice_d = (slice_q == SLICE_WIDTH'(TOTAL_MODULES - 1)) ? '0 : slice_q + SLICE_WIDTH'(1);
      if (last_beat) begin
        state_d[wr_sel_q] = FULL;
        wr_addr_d         = '0;
        wr_sel_d          = ~wr_sel_q;
      end else begin
        state_d[wr_sel_q] = FILLING;
        wr_addr_d         = wr_addr_q + ADDR_WIDTH'(1);
      end
    end
    // Reader transitions only ever hit FULL/READING banks, never the write bank.
    if (rd_start_i)   state_d[rd_bank_i] = READING;
    if (rd_release_i) state_d[rd_bank_i] = EMPTY;
    if (flush_i) begin
      state_d   = '{EMPTY, EMPTY};
      wr_sel_d  = 1'b0;
      wr_addr_d = '0;
      slice_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= '{EMPTY, EMPTY};
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      slice_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      slice_q   <= slice_d;
    end
  end

endmodule

// File: rtl/pp_bank_sched.sv
// Ping-pong bank scheduler: per-channel writers plus one shared reader that
// sweeps a bank RD_PASSES times across all channels before releasing it.
module pp_bank_sched
  import pp_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int TOTAL_MODULES = 4,
  parameter int RD_PASSES     = 1,
  parameter int RD_LATENCY    = 1,
  localparam int SLICE_WIDTH  = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             flush_i,
  input  logic [NUM_CH-1:0]                in_valid_i,
  output logic [NUM_CH-1:0]                in_ready_o,
  output logic [NUM_CH*SLICE_WIDTH-1:0]    slicing_idx_o,
  output logic [NUM_CH*2-1:0]              wea_o,
  output logic [NUM_CH*2*ADDR_WIDTH-1:0]   addra_o,
  output logic [1:0]                       enb_o,
  output logic [2*ADDR_WIDTH-1:0]          addrb_o,
  input  logic                             rd_step_i,
  output logic                             rd_data_valid_o,
  output logic                             rd_bank_o,
  output logic                             enable_matmul_o,
  output logic [NUM_CH*2-1:0]              bank_full_o
);

  localparam int PASS_WIDTH = (RD_PASSES > 1) ? $clog2(RD_PASSES) : 1;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic                  rd_start, rd_release, rd_run, all_full;
  logic [NUM_CH-1:0]     sel_full;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pp_wr_chan #(
      .DEPTH        (DEPTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .TOTAL_MODULES(TOTAL_MODULES),
      .SLICE_WIDTH  (SLICE_WIDTH)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .flush_i      (flush_i),
      .in_valid_i   (in_valid_i[g]),
      .in_ready_o   (in_ready_o[g]),
      .slicing_idx_o(slicing_idx_o[g*SLICE_WIDTH +: SLICE_WIDTH]),
      .wea_o        (wea_o[bank_idx(g, 0) +: 2]),
      .addra_o      (addra_o[addr_lsb(g, 0, ADDR_WIDTH) +: 2*ADDR_WIDTH]),
      .rd_bank_i    (rd_bank_q),
      .rd_start_i   (rd_start),
      .rd_release_i (rd_release),
      .bank_full_o  (bank_full_o[bank_idx(g, 0) +: 2])
    );
  end

  always_comb begin
    sel_full = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      sel_full[ch] = rd_bank_q ? bank_full_o[bank_idx(ch, 1)] : bank_full_o[bank_idx(ch, 0)];
  end
  assign all_full = &sel_full;

  assign rd_run    = (rd_state_q == R_RUN);
  assign rd_bank_o = rd_bank_q;

  always_comb begin
    rd_state_d      = rd_state_q;
    rd_bank_d       = rd_bank_q;
    rd_addr_d       = rd_addr_q;
    pass_d          = pass_q;
    rd_start        = 1'b0;
    rd_release      = 1'b0;
    enb_o           = '0;
    addrb_o         = '0;
    enable_matmul_o = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (all_full) begin
          rd_state_d = R_RUN;
          rd_addr_d  = '0;
          pass_d     = '0;
          rd_start   = 1'b1;
        end
      end
      R_RUN: begin
        enable_matmul_o  = 1'b1;
        enb_o[rd_bank_q] = 1'b1;
        if (rd_bank_q) addrb_o[2*ADDR_WIDTH-1:ADDR_WIDTH] = rd_addr_q;
        else           addrb_o[ADDR_WIDTH-1:0]            = rd_addr_q;
        if (rd_step_i) begin
          if (rd_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            rd_addr_d = '0;
            if (pass_q == PASS_WIDTH'(RD_PASSES - 1)) rd_state_d = R_RELEASE;
            else                                      pass_d     = pass_q + PASS_WIDTH'(1);
          end else begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      R_RELEASE: begin
        rd_release = 1'b1;
        rd_bank_d  = ~rd_bank_q;
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (flush_i) begin
      rd_state_d = R_IDLE;
      rd_bank_d  = 1'b0;
      rd_addr_d  = '0;
      pass_d     = '0;
      rd_start   = 1'b0;
      rd_release = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_state_q <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      pass_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      pass_q     <= pass_d;
    end
  end

  // enb[rd_bank] is high exactly while in R_RUN, so the valid pipe tracks rd_run.
  if (RD_LATENCY == 0) begin : g_vld_comb
    assign rd_data_valid_o = rd_run;
  end else begin : g_vld_pipe
    logic [RD_LATENCY-1:0] vld_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     vld_q <= '0;
      else if (flush_i) vld_q <= '0;
      else              vld_q <= (vld_q << 1) | RD_LATENCY'(rd_run);
    end
    assign rd_data_valid_o = vld_q[RD_LATENCY-1];
  end

endmodule
